pot_scan_ctrl: RTL and testbench
================================

POT_SCAN_CTRL -- requirements
Module: pot_scan_ctrl

Interface
REQ-001 Parameter MAX_COUNT, default 228: terminal pot count; a scan ends when the counter reaches it.
REQ-002 Parameter DUMP_STEPS, default 2: number of scan steps the pot capacitors are held discharged after a POTGO write.
REQ-003 clk  input  1  system clock; every flop is rising-edge on clk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 scan_tick  input  1  one-clk pulse per 15 kHz line; this is the slow-mode step.
REQ-006 fast_scan  input  1  SKCTL bit 2; when 1, every clk is a step.
REQ-007 potgo_wr  input  1  one-clk strobe from a write to the POTGO register.
REQ-008 pot_in  input  2  raw comparator levels: bit0 is the up/down pot, bit1 is the left/right pot; 1 means the capacitor is charged past threshold.
REQ-009 pot_dump  output  2  discharge drive per pot; 1 means the capacitor is shorted (release pins).
REQ-010 pot0_val  output  8  latched count for POT0.
REQ-011 pot1_val  output  8  latched count for POT1.
REQ-012 allpot  output  8  bit i (i=0,1) is 1 while pot i is still scanning; bits 7:2 are always 0.
REQ-013 busy  output  1  1 in DUMP or SCAN.

Function
REQ-014 pot_in SHALL pass through a 2-flop synchronizer per bit; only the synchronized value (pin_s) is used internally.
REQ-015 step = fast_scan ? 1 : scan_tick; the state machine and counter SHALL advance only on step, except on a potgo_wr restart.
REQ-016 States: IDLE, DUMP, SCAN.
REQ-017 IDLE: pot_dump=2'b11, busy=0, counter held at 0, pot values and allpot held.
REQ-018 potgo_wr in any state, on the next edge: counter=0, dump_cnt=0, allpot[1:0]=2'b11, state=DUMP. This restarts a scan that is in progress; pot values are not cleared.
REQ-019 DUMP: pot_dump=2'b11. On each step dump_cnt increments. When dump_cnt==DUMP_STEPS-1 on a step, state=SCAN and counter=0.
REQ-020 SCAN: pot_dump[i] = ~allpot[i]. An unfinished pot charges; a finished pot is re-dumped.
REQ-021 SCAN step, for each i with allpot[i]=1 and pin_s[i]=1: pot_i_val=counter and allpot[i]=0, on the same edge.
REQ-022 SCAN step, when neither pot is finishing and counter<MAX_COUNT: counter increments by 1. An 8-bit counter SHALL never wrap.
REQ-023 SCAN step with counter==MAX_COUNT: each pot with allpot[i]=1 latches MAX_COUNT and clears its bit; state=IDLE.
REQ-024 SCAN step that leaves allpot[1:0]=0 before MAX_COUNT: state=IDLE on that edge.
REQ-025 Both pots finishing on the same step SHALL both latch the same count.
REQ-026 A pot already high at the first SCAN step SHALL latch 0.
REQ-027 Changes to fast_scan mid-scan SHALL take effect on the next step; the counter keeps its value.
REQ-028 potgo_wr coincident with the step that ends a scan: the restart wins; latches from that step still occur.
REQ-029 busy and pot_dump SHALL be registered or decoded only from registered state; no combinational path from pot_in to any output.

Reset
REQ-030 While rst=1, asynchronously: state=IDLE, counter=0, dump_cnt=0, synchronizer flops=0, pot0_val=0, pot1_val=0, allpot=8'h00, pot_dump=2'b11, busy=0.
REQ-031 rst asserted mid-scan SHALL abort the scan with the values in REQ-030; no latch occurs.
REQ-032 After rst deasserts, the block SHALL stay in IDLE until potgo_wr.

Verification
REQ-033 fast_scan=1, DUMP_STEPS=2, potgo_wr, pot_in=2'b01 raised when counter=40 -> pot0_val=40 after the 2-flop delay plus 1, allpot=8'h02; pot_in[1] never high -> pot1_val=228, allpot=8'h00, busy=0.
REQ-034 fast_scan=0, scan_tick every 114 clks, pot_in=2'b11 at counter 10 -> pot0_val=pot1_val=the same value, scan ends early, pot_dump=2'b11.
REQ-035 pot_in=2'b11 held before potgo_wr -> both values latch 0 at the first SCAN step.
REQ-036 potgo_wr issued at counter=100 -> state=DUMP, allpot=8'h03, counter restarts at 0, previous pot values retained until relatched.
REQ-037 rst pulsed at counter=50 mid-scan -> all outputs equal the REQ-030 values immediately, without a clock edge; next potgo_wr scans normally.
REQ-038 pot_in bit 0 glitching high for 1 clk between steps in slow mode -> no latch unless pin_s is high on a step edge.

Source files
------------

// File: rtl/pot_scan_ctrl.sv
// pot_scan_ctrl: paddle pot scanner. It dumps the pot capacitors, counts scan
// steps while they charge, and latches each pot's count when its comparator trips.
`default_nettype none

module pot_scan_ctrl #(
   parameter int MAX_COUNT  = 228,
   parameter int DUMP_STEPS = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scan_tick,
   input  logic       fast_scan,
   input  logic       potgo_wr,
   input  logic [1:0] pot_in,
   output logic [1:0] pot_dump,
   output logic [7:0] pot0_val,
   output logic [7:0] pot1_val,
   output logic [7:0] allpot,
   output logic       busy
);

   localparam int              DW        = (DUMP_STEPS > 1) ? $clog2(DUMP_STEPS) : 1;
   localparam logic [7:0]      MAX_CNT   = 8'(MAX_COUNT);
   localparam logic [DW-1:0]   DUMP_LAST = DW'(DUMP_STEPS - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DUMP = 2'd1,
      ST_SCAN = 2'd2
   } state_t;

   state_t        state, state_nxt;
   logic [1:0]    pin_m, pin_s;
   logic [7:0]    counter, counter_nxt;
   logic [DW-1:0] dump_cnt, dump_cnt_nxt;
   logic [1:0]    pot_act, pot_act_nxt;
   logic [7:0]    pot0_nxt, pot1_nxt;
   logic [1:0]    finish;
   logic          step;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pin_m <= 2'b00;
         pin_s <= 2'b00;
      end else begin
         pin_m <= pot_in;
         pin_s <= pin_m;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         counter  <= 8'd0;
         dump_cnt <= '0;
         pot_act  <= 2'b00;
         pot0_val <= 8'd0;
         pot1_val <= 8'd0;
      end else begin
         state    <= state_nxt;
         counter  <= counter_nxt;
         dump_cnt <= dump_cnt_nxt;
         pot_act  <= pot_act_nxt;
         pot0_val <= pot0_nxt;
         pot1_val <= pot1_nxt;
      end
   end

   always_comb begin
      step         = fast_scan | scan_tick;
      state_nxt    = state;
      counter_nxt  = counter;
      dump_cnt_nxt = dump_cnt;
      pot_act_nxt  = pot_act;
      pot0_nxt     = pot0_val;
      pot1_nxt     = pot1_val;
      finish       = 2'b00;

      case (state)
         ST_IDLE: counter_nxt = 8'd0;
         ST_DUMP: begin
            if (step) begin
               if (dump_cnt == DUMP_LAST) begin
                  state_nxt   = ST_SCAN;
                  counter_nxt = 8'd0;
               end else begin
                  dump_cnt_nxt = dump_cnt + DW'(1);
               end
            end
         end
         ST_SCAN: begin
            if (step) begin
               // At the terminal count every still-active pot is forced to finish.
               finish = (counter >= MAX_CNT) ? pot_act : (pot_act & pin_s);
               if (finish[0]) pot0_nxt = counter;
               if (finish[1]) pot1_nxt = counter;
               pot_act_nxt = pot_act & ~finish;
               if ((counter >= MAX_CNT) || (pot_act_nxt == 2'b00)) begin
                  state_nxt   = ST_IDLE;
                  counter_nxt = 8'd0;
               end else if (finish == 2'b00) begin
                  counter_nxt = counter + 8'd1;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase

      // A restart overrides sequencing but the latches above still take effect.
      if (potgo_wr) begin
         state_nxt    = ST_DUMP;
         counter_nxt  = 8'd0;
         dump_cnt_nxt = '0;
         pot_act_nxt  = 2'b11;
      end
   end

   assign pot_dump = (state == ST_SCAN) ? ~pot_act : 2'b11;
   assign busy     = (state != ST_IDLE);
   assign allpot   = {6'b000000, pot_act};

endmodule

`default_nettype wire

// File: tb/tb_pot_scan_ctrl.sv
// tb_pot_scan_ctrl: scoreboard bench; each scan's expected pot values come from a
// closed-form model of first-trip step indices and are checked when busy falls.
`default_nettype none

module tb_pot_scan_ctrl;

   localparam int MAX  = 228;
   localparam int DS   = 2;
   localparam int TICK = 114;
   localparam int NEVER = 255;

   logic       clk = 1'b0;
   logic       rst;
   logic       scan_tick;
   logic       fast_scan;
   logic       potgo_wr;
   logic [1:0] pot_in;
   logic [1:0] pot_dump;
   logic [7:0] pot0_val, pot1_val, allpot;
   logic       busy;

   typedef struct packed {
      logic [7:0] p0;
      logic [7:0] p1;
   } exp_t;

   exp_t sb[$];
   exp_t last_done;
   int   compared   = 0;
   int   mismatched = 0;

   pot_scan_ctrl #(.MAX_COUNT(MAX), .DUMP_STEPS(DS)) dut (
      .clk(clk), .rst(rst), .scan_tick(scan_tick), .fast_scan(fast_scan),
      .potgo_wr(potgo_wr), .pot_in(pot_in), .pot_dump(pot_dump),
      .pot0_val(pot0_val), .pot1_val(pot1_val), .allpot(allpot), .busy(busy)
   );

   always #5 clk = ~clk;

   // Free-running 15 kHz line tick.
   initial begin
      int tc;
      tc = 0;
      scan_tick = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         tc++;
         scan_tick = (tc % TICK) == 0;
      end
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Pot i is first seen high at scan step s_i. Once the first pot finishes,
   // the counter skips one increment, so later steps read one less.
   function automatic exp_t model(input int s0, input int s1);
      exp_t e;
      int   sa, v0, v1;
      sa = (s0 < s1) ? s0 : s1;
      if (sa >= MAX) begin
         v0 = MAX;
         v1 = MAX;
      end else begin
         v0 = (s0 == sa) ? sa : ((s0 - 1 < MAX) ? s0 - 1 : MAX);
         v1 = (s1 == sa) ? sa : ((s1 - 1 < MAX) ? s1 - 1 : MAX);
      end
      e.p0 = 8'(v0);
      e.p1 = 8'(v1);
      return e;
   endfunction

   task automatic step_clk();
      @(posedge clk);
      #2;
   endtask

   // abort_kind: 0 = none, 1 = potgo restart, 2 = reset; abort_at is the counter value.
   task automatic run_scan(input bit fast, input int s0, input int s1, input bit pre,
                           input int abort_kind, input int abort_at, input int glitch_n);
      int tgt0, tgt1, n, guard;
      bit glitched, gnow, was_step, done;
      exp_t e;
      fast_scan = fast;
      pot_in    = pre ? 2'b11 : 2'b00;
      repeat (4) step_clk();
      tgt0 = DS + s0 - (fast ? 2 : 0);
      tgt1 = DS + s1 - (fast ? 2 : 0);
      e = model(s0, s1);
      if (abort_kind == 0) sb.push_back(e);
      potgo_wr = 1'b1;
      step_clk();
      potgo_wr = 1'b0;
      n = 0;
      glitched = 1'b0;
      done = 1'b0;
      for (guard = 0; guard < 40000; guard++) begin
         gnow = 1'b0;
         if (glitch_n >= 0 && n == glitch_n && !glitched) begin
            gnow = 1'b1;
            glitched = 1'b1;
         end
         pot_in[0] = pre | (n >= tgt0) | gnow;
         pot_in[1] = pre | (n >= tgt1);
         if (abort_kind == 1 && n == DS + abort_at) begin
            potgo_wr = 1'b1;
            step_clk();
            potgo_wr = 1'b0;
            check("restart_allpot", allpot, 8'h03);
            check("restart_busy", {7'd0, busy}, 8'd1);
            check("restart_dump", {6'd0, pot_dump}, 8'd3);
            check("restart_pot0_kept", pot0_val, last_done.p0);
            check("restart_pot1_kept", pot1_val, last_done.p1);
            return;
         end
         if (abort_kind == 2 && n == DS + abort_at) begin
            e.p0 = 8'd0;
            e.p1 = 8'd0;
            sb.push_back(e);
            rst = 1'b1;
            #1;
            check("rst_async_pot0", pot0_val, 8'd0);
            check("rst_async_pot1", pot1_val, 8'd0);
            check("rst_async_allpot", allpot, 8'd0);
            check("rst_async_dump", {6'd0, pot_dump}, 8'd3);
            check("rst_async_busy", {7'd0, busy}, 8'd0);
            #4;
            rst = 1'b0;
            pot_in = 2'b00;
            step_clk();
            last_done = e;
            return;
         end
         if (!busy) begin
            done = 1'b1;
            break;
         end
         was_step = fast_scan | scan_tick;
         step_clk();
         if (was_step) n++;
      end
      if (!done) begin
         compared++;
         mismatched++;
         $display("FAIL scan_timeout: busy still 1, expected 0 (s0=%0d s1=%0d)", s0, s1);
      end
      last_done = e;
      pot_in = 2'b00;
   endtask

   // Monitor: every falling edge of busy presents a finished (or aborted) scan.
   initial begin
      logic busy_d;
      exp_t e;
      busy_d = 1'b0;
      forever begin
         @(negedge clk);
         if (busy_d && !busy) begin
            if (sb.size() == 0) begin
               compared++;
               mismatched++;
               $display("FAIL sb_underflow: got scan end, expected none");
            end else begin
               e = sb.pop_front();
               check("pot0_val", pot0_val, e.p0);
               check("pot1_val", pot1_val, e.p1);
               check("end_allpot", allpot, 8'h00);
               check("end_dump", {6'd0, pot_dump}, 8'd3);
            end
         end
         busy_d = busy;
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation still running, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      fast_scan = 1'b0;
      potgo_wr = 1'b0;
      pot_in = 2'b00;
      last_done = '0;
      #3;
      check("reset_pot0", pot0_val, 8'd0);
      check("reset_pot1", pot1_val, 8'd0);
      check("reset_allpot", allpot, 8'd0);
      check("reset_dump", {6'd0, pot_dump}, 8'd3);
      check("reset_busy", {7'd0, busy}, 8'd0);
      repeat (3) step_clk();
      rst = 1'b0;
      fast_scan = 1'b1;
      pot_in = 2'b11;
      repeat (10) step_clk();
      check("idle_after_reset", {7'd0, busy}, 8'd0);
      check("idle_pot0", pot0_val, 8'd0);
      pot_in = 2'b00;

      run_scan(1'b1, 40, NEVER, 1'b0, 0, 0, -1);
      run_scan(1'b0, 10, 10, 1'b0, 0, 0, -1);
      run_scan(1'b1, 0, 0, 1'b1, 0, 0, -1);
      run_scan(1'b1, NEVER, NEVER, 1'b0, 1, 100, -1);
      run_scan(1'b1, 30, 12, 1'b0, 0, 0, -1);
      run_scan(1'b1, NEVER, NEVER, 1'b0, 2, 50, -1);
      run_scan(1'b1, 5, 60, 1'b0, 0, 0, -1);
      run_scan(1'b0, 8, 4, 1'b0, 0, 0, DS + 3);
      run_scan(1'b1, 228, 100, 1'b0, 0, 0, -1);
      run_scan(1'b1, 229, NEVER, 1'b0, 0, 0, -1);
      run_scan(1'b1, 227, 229, 1'b0, 0, 0, -1);
      for (int i = 0; i < 8; i++)
         run_scan(1'b1, int'($urandom_range(0, 240)), int'($urandom_range(0, 240)), 1'b0, 0, 0, -1);
      for (int i = 0; i < 3; i++)
         run_scan(1'b0, int'($urandom_range(0, 12)), int'($urandom_range(0, 12)), 1'b0, 0, 0, -1);

      repeat (5) step_clk();
      if (sb.size() != 0) begin
         compared++;
         mismatched++;
         $display("FAIL sb_leftover: got %0d pending, expected 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

`default_nettype wire
